// File: rtl/imem_axil_bridge_if.sv
// Fetch-unit request/response and AXI4-Lite read-channel signals of the instruction-memory bridge.
// master = bridge side; slave = fetch unit plus memory side.
interface imem_axil_bridge_if;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        flush;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    input  req_addr, req_valid, flush, m_arready, m_rdata, m_rresp, m_rvalid,
    output resp_valid, resp_data, resp_err, m_araddr, m_arvalid, m_arprot, m_rready
  );

  modport slave (
    output req_addr, req_valid, flush, m_arready, m_rdata, m_rresp, m_rvalid,
    input  resp_valid, resp_data, resp_err, m_araddr, m_arvalid, m_arprot, m_rready
  );
endinterface

// File: rtl/imem_axil_bridge.sv
// Fetch-to-AXI4-Lite read bridge, one outstanding read; resp_valid 3 cycles after request (1 for misaligned/hit).
// AR/R stall indefinitely on arready/rvalid with stable arvalid/araddr; IMEM_LAST_HIT_EN adds a one-entry last-hit buffer.
module imem_axil_bridge #(
  parameter logic [2:0]  ARPROT_VAL    = 3'b100,
  parameter logic [31:0] RESP_ERR_DATA = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  imem_axil_bridge_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        lookup_hit;
  logic [31:0] lookup_dat;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr[1:0] != 2'b00) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = RESP_ERR_DATA;
          end else if (lookup_hit) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = lookup_dat;
          end else begin
            araddr_d  = bus.req_addr;
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end
        end
      end
      S_AR: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (bus.m_rvalid) begin
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
          if (bus.m_rresp == 2'b00) begin
            resp_err_d  = 1'b0;
            resp_data_d = bus.m_rdata;
          end else begin
            resp_err_d  = 1'b1;
            resp_data_d = RESP_ERR_DATA;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

`ifdef IMEM_LAST_HIT_EN
  logic        hit_vld_q, hit_vld_d;
  logic [29:0] hit_tag_q, hit_tag_d;
  logic [31:0] hit_dat_q, hit_dat_d;
  logic        no_fill_q, no_fill_d;
  logic        fill;

  assign fill       = (state_q == S_R) && bus.m_rvalid && (bus.m_rresp == 2'b00);
  assign lookup_hit = hit_vld_q && !bus.flush && (hit_tag_q == bus.req_addr[31:2]);
  assign lookup_dat = hit_dat_q;

  // A flush seen while the read is in flight poisons that read's fill.
  always_comb begin
    hit_vld_d = hit_vld_q;
    hit_tag_d = hit_tag_q;
    hit_dat_d = hit_dat_q;
    no_fill_d = (state_q == S_IDLE) ? 1'b0 : (no_fill_q | bus.flush);
    if (fill && !no_fill_q) begin
      hit_vld_d = 1'b1;
      hit_tag_d = araddr_q[31:2];
      hit_dat_d = bus.m_rdata;
    end
    if (bus.flush) begin
      hit_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_vld_q <= 1'b0;
      hit_tag_q <= '0;
      hit_dat_q <= '0;
      no_fill_q <= 1'b0;
    end else begin
      hit_vld_q <= hit_vld_d;
      hit_tag_q <= hit_tag_d;
      hit_dat_q <= hit_dat_d;
      no_fill_q <= no_fill_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign lookup_hit   = 1'b0;
  assign lookup_dat   = '0;
`endif

  assign bus.m_araddr   = araddr_q;
  assign bus.m_arvalid  = arvalid_q;
  assign bus.m_arprot   = ARPROT_VAL;
  assign bus.m_rready   = rready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_axil_bridge.sv
// Randomized bench for imem_axil_bridge: AXI-Lite slave with programmable stalls, monitor, and a transaction-level model.
module tb_imem_axil_bridge;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_LAST_HIT_EN
  localparam bit LAST_HIT = 1'b1;
`else
  localparam bit LAST_HIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_axil_bridge_if bus_if ();
  imem_axil_bridge #(.ARPROT_VAL(3'b100), .RESP_ERR_DATA(NOP)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0;
  int failures = 0;

  int          cfg_ard = 0;
  int          cfg_rd = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;

  int ar_hs = 0, r_hs = 0, resp_pulses = 0, arv_cycles = 0, stab_viol = 0;
  logic [31:0] last_araddr = '0;

  bit          mb_vld = 1'b0;
  logic [29:0] mb_tag = '0;
  logic [31:0] mb_dat = '0;

  // AXI-Lite slave: drives just after the active edge, honouring cfg stall counts.
  initial begin : slave
    int ar_wait, r_wait;
    bit r_pend;
    ar_wait = 0; r_wait = 0; r_pend = 1'b0;
    bus_if.m_arready = 1'b0;
    bus_if.m_rvalid  = 1'b0;
    bus_if.m_rdata   = '0;
    bus_if.m_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus_if.m_arready = 1'b0;
        bus_if.m_rvalid  = 1'b0;
        r_pend = 1'b0; ar_wait = 0; r_wait = 0;
      end else begin
        if (bus_if.m_arready) begin
          bus_if.m_arready = 1'b0;
          r_pend = 1'b1;
          r_wait = 0;
        end else if (bus_if.m_arvalid) begin
          if (ar_wait >= cfg_ard) begin
            bus_if.m_arready = 1'b1;
            ar_wait = 0;
          end else ar_wait++;
        end
        if (bus_if.m_rvalid) begin
          bus_if.m_rvalid = 1'b0;
          r_pend = 1'b0;
        end else if (r_pend) begin
          if (r_wait >= cfg_rd) begin
            bus_if.m_rvalid = 1'b1;
            bus_if.m_rdata  = cfg_rdata;
            bus_if.m_rresp  = cfg_rresp;
          end else r_wait++;
        end
      end
    end
  end

  initial begin : monitor
    bit prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (bus_if.m_arvalid === 1'b1 && bus_if.m_arready === 1'b1) begin
        ar_hs++;
        last_araddr = bus_if.m_araddr;
      end
      if (bus_if.m_rvalid === 1'b1 && bus_if.m_rready === 1'b1) r_hs++;
      if (bus_if.resp_valid === 1'b1) resp_pulses++;
      if (bus_if.m_arvalid === 1'b1) arv_cycles++;
      if (prev_wait && !rst && (bus_if.m_arvalid !== 1'b1 || bus_if.m_araddr !== prev_addr)) stab_viol++;
      prev_wait = (bus_if.m_arvalid === 1'b1) && (bus_if.m_arready !== 1'b1);
      prev_addr = bus_if.m_araddr;
    end
  end

  // Transaction-level reference: misaligned -> NOP/err in 1 cycle, buffer hit -> 1 cycle,
  // otherwise one bus read taking 3 cycles plus slave stalls.
  task automatic model_fetch(input logic [31:0] addr, input int fa, output bit e_bus,
                             output logic [31:0] e_data, output logic e_err, output int e_lat);
    bit flushed;
    e_bus = 1'b0; e_lat = 1; e_err = 1'b1; e_data = NOP;
    if (addr[1:0] == 2'b00) begin
      if (LAST_HIT && mb_vld && mb_tag == addr[31:2]) begin
        e_data = mb_dat; e_err = 1'b0;
      end else begin
        e_bus = 1'b1;
        e_lat = 3 + cfg_ard + cfg_rd;
        if (cfg_rresp == 2'b00) begin
          e_data = cfg_rdata; e_err = 1'b0;
        end
      end
    end
    flushed = (fa >= 1) && (fa < e_lat);
    if (LAST_HIT && e_bus && !e_err && !flushed) begin
      mb_vld = 1'b1; mb_tag = addr[31:2]; mb_dat = cfg_rdata;
    end
    if (flushed) mb_vld = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int flush_at,
                          output logic [31:0] o_data, output logic o_err, output int o_lat,
                          output int o_ar, output int o_pulses, output logic o_after,
                          output logic [31:0] o_araddr, output bit o_timeout);
    int ar0, p0, cyc;
    bit got;
    ar0 = ar_hs; p0 = resp_pulses;
    bus_if.req_addr  = addr;
    bus_if.req_valid = 1'b1;
    cyc = 0; got = 1'b0; o_data = '0; o_err = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus_if.flush = (cyc == flush_at);
      if (bus_if.resp_valid === 1'b1) begin
        got = 1'b1; o_data = bus_if.resp_data; o_err = bus_if.resp_err;
      end
    end
    bus_if.req_valid = 1'b0;
    bus_if.flush = 1'b0;
    o_lat = cyc; o_timeout = !got;
    @(negedge clk);
    o_after = bus_if.resp_valid;
    #1;
    o_ar = ar_hs - ar0; o_pulses = resp_pulses - p0; o_araddr = last_araddr;
  endtask

  task automatic do_flush;
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    mb_vld = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.req_addr = '0; bus_if.flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", bus_if.resp_valid); end
    checks++; if (bus_if.resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b want=0", bus_if.resp_err); end
    checks++; if (bus_if.resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h want=0", bus_if.resp_data); end
    checks++; if (bus_if.m_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b want=0", bus_if.m_arvalid); end
    checks++; if (bus_if.m_rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b want=0", bus_if.m_rready); end
    checks++; if (bus_if.m_araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%h want=0", bus_if.m_araddr); end
    checks++; if (bus_if.m_arprot !== 3'b100) begin failures++; $display("FAIL arprot got=%b want=100", bus_if.m_arprot); end
    rst = 1'b0;
    mb_vld = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [31:0] od, oa, ed; logic oe, ee, oaf; int ol, oar, op, el; bit eb, to;
    cfg_ard = 0; cfg_rd = 0; cfg_rdata = 32'h0010_0093; cfg_rresp = 2'b00;
    model_fetch(32'h8000_0000, -1, eb, ed, ee, el);
    do_fetch(32'h8000_0000, -1, od, oe, ol, oar, op, oaf, oa, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b want=0", to); end
    checks++; if ({oe, od} !== {ee, ed}) begin failures++; $display("FAIL basic_resp got=%b/%h want=%b/%h", oe, od, ee, ed); end
    checks++; if (ol !== 3 || ol !== el) begin failures++; $display("FAIL basic_latency got=%0d want=3", ol); end
    checks++; if (oa !== 32'h8000_0000) begin failures++; $display("FAIL basic_araddr got=%h want=80000000", oa); end
    checks++; if (oar !== 1) begin failures++; $display("FAIL basic_ar_count got=%0d want=1", oar); end
    checks++; if (op !== 1 || oaf !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%0d/%b want=1/0", op, oaf); end
  endtask

  task automatic test_backpressure;
    logic [31:0] od, oa, ed; logic oe, ee, oaf; int ol, oar, op, el, r0, av0, sv0; bit eb, to;
    cfg_ard = 5; cfg_rd = 4; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    r0 = r_hs; av0 = arv_cycles; sv0 = stab_viol;
    model_fetch(32'h8000_0040, -1, eb, ed, ee, el);
    do_fetch(32'h8000_0040, -1, od, oe, ol, oar, op, oaf, oa, to);
    checks++; if ({oe, od} !== {ee, ed}) begin failures++; $display("FAIL bp_resp got=%b/%h want=%b/%h", oe, od, ee, ed); end
    checks++; if (ol !== el) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", ol, el); end
    checks++; if (stab_viol - sv0 !== 0) begin failures++; $display("FAIL bp_ar_stable got=%0d violations want=0", stab_viol - sv0); end
    checks++; if (arv_cycles - av0 !== 6) begin failures++; $display("FAIL bp_arvalid_cycles got=%0d want=6", arv_cycles - av0); end
    checks++; if (oar !== 1 || r_hs - r0 !== 1) begin failures++; $display("FAIL bp_handshakes got=ar%0d/r%0d want=1/1", oar, r_hs - r0); end
    checks++; if (op !== 1 || oaf !== 1'b0) begin failures++; $display("FAIL bp_pulse got=%0d/%b want=1/0", op, oaf); end
    checks++; if (oa !== 32'h8000_0040) begin failures++; $display("FAIL bp_araddr got=%h want=80000040", oa); end
  endtask

  task automatic test_misaligned;
    logic [31:0] od, oa, ed, addr; logic oe, ee, oaf; int ol, oar, op, el, av0; bit eb, to;
    cfg_ard = 0; cfg_rd = 0; cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
    for (int k = 1; k < 4; k++) begin
      addr = 32'h8000_0000 | 32'(k);
      av0 = arv_cycles;
      model_fetch(addr, -1, eb, ed, ee, el);
      do_fetch(addr, -1, od, oe, ol, oar, op, oaf, oa, to);
      checks++; if ({oe, od} !== {1'b1, NOP}) begin failures++; $display("FAIL misaligned_resp addr=%h got=%b/%h want=1/%h", addr, oe, od, NOP); end
      checks++; if (ol !== 1 || ol !== el) begin failures++; $display("FAIL misaligned_latency addr=%h got=%0d want=1", addr, ol); end
      checks++; if (oar !== 0 || arv_cycles - av0 !== 0) begin failures++; $display("FAIL misaligned_no_ar addr=%h got=%0d/%0d want=0/0", addr, oar, arv_cycles - av0); end
    end
  endtask

  task automatic test_bus_error;
    logic [31:0] od, oa, ed; logic oe, ee, oaf; int ol, oar, op, el; bit eb, to;
    logic [1:0] resps [2];
    resps[0] = 2'b10; resps[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      cfg_ard = k; cfg_rd = 1; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = resps[k];
      model_fetch(32'h8000_0080 + 32'(k * 4), -1, eb, ed, ee, el);
      do_fetch(32'h8000_0080 + 32'(k * 4), -1, od, oe, ol, oar, op, oaf, oa, to);
      checks++; if ({oe, od} !== {1'b1, NOP}) begin failures++; $display("FAIL buserr_resp rresp=%b got=%b/%h want=1/%h", resps[k], oe, od, NOP); end
      checks++; if (ol !== el) begin failures++; $display("FAIL buserr_latency got=%0d want=%0d", ol, el); end
      checks++; if (oar !== 1) begin failures++; $display("FAIL buserr_ar_count got=%0d want=1", oar); end
    end
  endtask

  task automatic test_reset_mid_r;
    logic [31:0] od, oa, ed; logic oe, ee, oaf; int ol, oar, op, el; bit eb, to;
    cfg_ard = 0; cfg_rd = 8; cfg_rdata = 32'h0BAD_0BAD; cfg_rresp = 2'b00;
    bus_if.req_addr = 32'h8000_00C0;
    bus_if.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.m_rready !== 1'b1) begin failures++; $display("FAIL midr_in_r got rready=%b want=1", bus_if.m_rready); end
    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.m_arvalid !== 1'b0) begin failures++; $display("FAIL midr_arvalid got=%b want=0", bus_if.m_arvalid); end
    checks++; if (bus_if.m_rready !== 1'b0) begin failures++; $display("FAIL midr_rready got=%b want=0", bus_if.m_rready); end
    checks++; if (bus_if.resp_valid !== 1'b0) begin failures++; $display("FAIL midr_resp_valid got=%b want=0", bus_if.resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    mb_vld = 1'b0;
    #1;
    cfg_rd = 0; cfg_rdata = 32'h0040_0113;
    model_fetch(32'h8000_0004, -1, eb, ed, ee, el);
    do_fetch(32'h8000_0004, -1, od, oe, ol, oar, op, oaf, oa, to);
    checks++; if ({oe, od} !== {ee, ed}) begin failures++; $display("FAIL midr_next_resp got=%b/%h want=%b/%h", oe, od, ee, ed); end
    checks++; if (ol !== el || oar !== 1) begin failures++; $display("FAIL midr_next_timing got=lat%0d/ar%0d want=lat%0d/ar1", ol, oar, el); end
    checks++; if (oa !== 32'h8000_0004) begin failures++; $display("FAIL midr_next_araddr got=%h want=80000004", oa); end
  endtask

  task automatic test_last_hit;
    logic [31:0] od, oa, ed; logic oe, ee, oaf; int ol, oar, op, el; bit eb, to;
    logic [31:0] addrs [5];
    int fas [5];
    addrs[0] = 32'h8000_0010; addrs[1] = 32'h8000_0010; addrs[2] = 32'h8000_0010;
    addrs[3] = 32'h8000_0020; addrs[4] = 32'h8000_0020;
    fas[0] = -1; fas[1] = -1; fas[2] = -1; fas[3] = 2; fas[4] = -1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) do_flush();
      cfg_ard = (k == 3) ? 1 : 0; cfg_rd = (k == 3) ? 1 : 0;
      cfg_rdata = 32'h1000_0000 + 32'(k); cfg_rresp = 2'b00;
      model_fetch(addrs[k], fas[k], eb, ed, ee, el);
      do_fetch(addrs[k], fas[k], od, oe, ol, oar, op, oaf, oa, to);
      checks++; if ({oe, od} !== {ee, ed}) begin failures++; $display("FAIL lasthit_resp step=%0d got=%b/%h want=%b/%h", k, oe, od, ee, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL lasthit_latency step=%0d got=%0d want=%0d", k, ol, el); end
      checks++; if (oar !== int'(eb)) begin failures++; $display("FAIL lasthit_ar_count step=%0d got=%0d want=%0d", k, oar, eb); end
    end
  endtask

  task automatic test_random;
    logic [31:0] od, oa, ed, addr; logic oe, ee, oaf; int ol, oar, op, el, fa; bit eb, to;
    for (int i = 0; i < 60; i++) begin
      addr = 32'h8000_0100 + ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      cfg_ard = $urandom_range(0, 3);
      cfg_rd = $urandom_range(0, 3);
      cfg_rdata = $urandom;
      cfg_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 4) == 0) do_flush();
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2 + cfg_ard + cfg_rd)) : -1;
      model_fetch(addr, fa, eb, ed, ee, el);
      do_fetch(addr, fa, od, oe, ol, oar, op, oaf, oa, to);
      checks++; if ({oe, od} !== {ee, ed}) begin failures++; $display("FAIL rand_resp i=%0d addr=%h got=%b/%h want=%b/%h", i, addr, oe, od, ee, ed); end
      checks++; if (ol !== el) begin failures++; $display("FAIL rand_latency i=%0d got=%0d want=%0d", i, ol, el); end
      checks++; if (oar !== int'(eb)) begin failures++; $display("FAIL rand_ar_count i=%0d got=%0d want=%0d", i, oar, eb); end
      checks++; if (op !== 1 || oaf !== 1'b0) begin failures++; $display("FAIL rand_pulse i=%0d got=%0d/%b want=1/0", i, op, oaf); end
      if (eb) begin
        checks++; if (oa !== addr) begin failures++; $display("FAIL rand_araddr i=%0d got=%h want=%h", i, oa, addr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_bus_error();
    test_reset_mid_r();
    test_last_hit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
